// File: rtl/mode_sequencer_pkg.sv
// mode_sequencer_pkg: state, mode and 7-segment digit codes shared by the mode sequencer.
package mode_sequencer_pkg;
    localparam logic [2:0] S_IDLE = 3'd0, S_AUTO = 3'd1, S_FREE = 3'd2, S_LEARN = 3'd3, S_RESULT = 3'd4;
    localparam logic [2:0] MODE_AUTO = 3'b011, MODE_FREE = 3'b001, MODE_LEARN = 3'b111;
    localparam logic [4:0] C_A = 5'd10, C_U = 5'd11, C_T = 5'd12, C_O = 5'd13, C_H = 5'd14, C_E = 5'd15;
    localparam logic [4:0] C_L = 5'd16, C_F = 5'd17, C_R = 5'd18, C_N = 5'd19, C_S = 5'd20, C_BLANK = 5'd31;
    localparam logic [19:0] DIG_AUTO = {C_A, C_U, C_T, C_O};
    localparam logic [19:0] DIG_FREE = {C_F, C_R, C_E, C_E};
    localparam logic [14:0] DIG_LRN = {C_L, C_R, C_N};
    localparam logic [24:0] DIG_HELLO = {C_H, C_E, C_L, C_L, C_O};
    localparam logic [14:0] DIG_EMPTY3 = {3{C_BLANK}};
    localparam logic [19:0] DIG_EMPTY4 = {4{C_BLANK}};
    localparam logic [4:0] DIG_U = C_U, DIG_S = C_S;

    function automatic logic [2:0] decode_mode(input logic [2:0] m);
        return m == MODE_AUTO ? S_AUTO : m == MODE_FREE ? S_FREE : m == MODE_LEARN ? S_LEARN : S_IDLE;
    endfunction
endpackage

// File: rtl/score_record_table.sv
// score_record_table: best-score RAM with valid bits, compare-and-write and write-first sync read.
module score_record_table #(
    parameter int DEPTH = 16,
    parameter int W = 33,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] idx,
    input  logic          we_req,
    input  logic [W-1:0]  score,
    output logic          hit,
    output logic [W-1:0]  rd
);
    logic [W-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;

    assign hit = we_req && (!valid[idx] || score > mem[idx]);

    always_ff @(posedge clk)
        if (hit) mem[idx] <= score;

    // Reset only clears valid bits; stale RAM contents are masked to zero on read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            rd <= '0;
        end else begin
            if (hit) valid[idx] <= 1'b1;
            rd <= hit ? score : valid[idx] ? mem[idx] : '0;
        end
    end
endmodule

// File: rtl/mode_sequencer.sv
// mode_sequencer: debounced piano mode FSM steering speaker, LEDs and digits, with result screen
// and per-user/per-song best-score table.
module mode_sequencer import mode_sequencer_pkg::*; #(
    parameter int NUM_USERS = 4,
    parameter int NUM_SONGS = 4,
    parameter int SCORE_W = 33,
    parameter int SETTLE_CYCLES = 1_000_000,
    parameter int MUTE_CYCLES = 500_000,
    parameter int RESULT_HOLD = 500_000_000,
    localparam int UW = $clog2(NUM_USERS),
    localparam int SW = $clog2(NUM_SONGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         mode,
    input  logic [SW-1:0]      song_num,
    input  logic [UW-1:0]      user,
    input  logic [2:0]         spk_src,
    input  logic [7:0]         led_auto,
    input  logic [7:0]         led_learn,
    input  logic               finished,
    input  logic [SCORE_W-1:0] score,
    input  logic [19:0]        level_digits,
    output logic               speaker,
    output logic [7:0]         led,
    output logic [39:0]        digits,
    output logic [SCORE_W-1:0] rec_score,
    output logic               new_best
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int MW = $clog2(MUTE_CYCLES + 1);
    localparam int HW = $clog2(RESULT_HOLD + 1);

    logic [2:0] cand, state, state_n, target, base;
    logic [CW-1:0] cnt;
    logic [MW-1:0] mute, mute_n;
    logic [HW-1:0] hold;
    logic [UW-1:0] lat_user, lat_user_n;
    logic [SW-1:0] lat_song, lat_song_n;
    logic finished_q, stable, settled, commit, fin_ok, hit, spk_n, learnish;
    logic [7:0] led_n;
    logic [39:0] digits_n;

    score_record_table #(.DEPTH(NUM_USERS * NUM_SONGS), .W(SCORE_W)) u_table (
        .clk(clk), .rst(rst), .idx({user, song_num}), .we_req(fin_ok),
        .score(score), .hit(hit), .rd(rec_score)
    );

    // Outputs are registered from the next state so a commit shows on the commit edge itself.
    always_comb begin
        stable = mode == cand;
        settled = cnt == CW'(SETTLE_CYCLES - 1);
        target = decode_mode(mode);
        base = state == S_RESULT ? S_LEARN : state;
        commit = stable && settled && target != base;
        fin_ok = finished && !finished_q && state == S_LEARN;
        state_n = commit ? target : fin_ok ? S_RESULT :
                  (state == S_RESULT && hold == HW'(RESULT_HOLD - 1)) ? S_LEARN : state;
        mute_n = commit ? MW'(MUTE_CYCLES) : mute != '0 ? mute - MW'(1) : mute;
        lat_user_n = fin_ok ? user : lat_user;
        lat_song_n = fin_ok ? song_num : lat_song;
        learnish = state_n == S_LEARN || state_n == S_RESULT;
        spk_n = mute_n == '0 && (state_n == S_AUTO ? spk_src[0] : state_n == S_FREE ? spk_src[1] :
                                 learnish ? spk_src[2] : 1'b0);
        led_n = state_n == S_AUTO ? led_auto : learnish ? led_learn : 8'h00;
        digits_n = state_n == S_AUTO  ? {DIG_AUTO, DIG_EMPTY3, 5'(song_num)} :
                   state_n == S_FREE  ? {DIG_FREE, DIG_EMPTY4} :
                   state_n == S_LEARN ? {DIG_LRN, DIG_EMPTY4, 5'(song_num)} :
                   state_n == S_RESULT ? {DIG_U, 5'(lat_user_n), DIG_S, 5'(lat_song_n), level_digits} :
                   {DIG_HELLO, DIG_EMPTY3};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand <= '0;
            cnt <= '0;
            state <= S_IDLE;
            mute <= '0;
            hold <= '0;
            finished_q <= 1'b0;
            lat_user <= '0;
            lat_song <= '0;
            speaker <= 1'b0;
            led <= '0;
            digits <= {DIG_HELLO, DIG_EMPTY3};
            new_best <= 1'b0;
        end else begin
            cand <= mode;
            cnt <= !stable ? '0 : settled ? cnt : cnt + CW'(1);
            state <= state_n;
            mute <= mute_n;
            hold <= (state == S_RESULT && state_n == S_RESULT) ? hold + HW'(1) : '0;
            finished_q <= finished;
            lat_user <= lat_user_n;
            lat_song <= lat_song_n;
            speaker <= spk_n;
            led <= led_n;
            digits <= digits_n;
            new_best <= state_n == S_RESULT && (state == S_RESULT ? new_best : hit);
        end
    end
endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer: directed scenario bench for mode_sequencer with short settle/mute/hold times.
module tb_mode_sequencer;
    import mode_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] mode;
    logic [1:0] song_num, user;
    logic [2:0] spk_src;
    logic [7:0] led_auto, led_learn;
    logic finished;
    logic [32:0] score;
    logic [19:0] level_digits;
    logic speaker, new_best;
    logic [7:0] led;
    logic [39:0] digits;
    logic [32:0] rec_score;
    int vectors = 0, miscompares = 0;

    localparam logic [39:0] EXP_IDLE = {DIG_HELLO, DIG_EMPTY3};
    localparam logic [39:0] EXP_AUTO2 = {DIG_AUTO, DIG_EMPTY3, 5'd2};
    localparam logic [39:0] EXP_FREE = {DIG_FREE, DIG_EMPTY4};
    localparam logic [39:0] EXP_LRN3 = {DIG_LRN, DIG_EMPTY4, 5'd3};
    localparam logic [19:0] LVL = 20'h12345;
    localparam logic [39:0] EXP_RES13 = {5'd11, 5'd1, 5'd20, 5'd3, LVL};

    mode_sequencer #(.SETTLE_CYCLES(4), .MUTE_CYCLES(3), .RESULT_HOLD(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .song_num(song_num), .user(user),
        .spk_src(spk_src), .led_auto(led_auto), .led_learn(led_learn),
        .finished(finished), .score(score), .level_digits(level_digits),
        .speaker(speaker), .led(led), .digits(digits), .rec_score(rec_score), .new_best(new_best)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go_mode(input logic [2:0] m);
        mode = m;
        step(8);
    endtask

    task automatic test_reset;
        rst = 1'b1; mode = 3'b000; song_num = 2'd0; user = 2'd0; spk_src = 3'b111;
        led_auto = 8'hA5; led_learn = 8'h3C; finished = 1'b0; score = '0; level_digits = LVL;
        step(2);
        vectors++; if (speaker !== 1'b0) begin miscompares++; $display("FAIL reset_speaker got %b exp 0", speaker); end
        vectors++; if (led !== 8'h00) begin miscompares++; $display("FAIL reset_led got %h exp 00", led); end
        vectors++; if (digits !== EXP_IDLE) begin miscompares++; $display("FAIL reset_digits got %h exp %h", digits, EXP_IDLE); end
        vectors++; if (rec_score !== 33'd0) begin miscompares++; $display("FAIL reset_rec got %0d exp 0", rec_score); end
        vectors++; if (new_best !== 1'b0) begin miscompares++; $display("FAIL reset_new_best got %b exp 0", new_best); end
        rst = 1'b0;
        step(6);
        vectors++; if (digits !== EXP_IDLE) begin miscompares++; $display("FAIL idle_digits got %h exp %h", digits, EXP_IDLE); end
    endtask

    task automatic test_auto;
        mode = MODE_AUTO; song_num = 2'd2;
        step(4);
        vectors++; if (digits !== EXP_IDLE) begin miscompares++; $display("FAIL auto_early got %h exp %h", digits, EXP_IDLE); end
        step(1);
        vectors++; if (digits !== EXP_AUTO2) begin miscompares++; $display("FAIL auto_digits got %h exp %h", digits, EXP_AUTO2); end
        vectors++; if (led !== 8'hA5) begin miscompares++; $display("FAIL auto_led got %h exp a5", led); end
        for (int i = 5; i <= 7; i++) begin
            vectors++; if (speaker !== 1'b0) begin miscompares++; $display("FAIL auto_mute cycle %0d got %b exp 0", i, speaker); end
            step(1);
        end
        vectors++; if (speaker !== 1'b1) begin miscompares++; $display("FAIL auto_unmute got %b exp 1", speaker); end
        spk_src = 3'b110;
        step(1);
        vectors++; if (speaker !== 1'b0) begin miscompares++; $display("FAIL auto_follow got %b exp 0", speaker); end
        spk_src = 3'b111;
        step(1);
    endtask

    task automatic test_glitch;
        mode = MODE_FREE;
        step(2);
        mode = MODE_AUTO;
        for (int i = 0; i < 8; i++) begin
            step(1);
            vectors++; if (speaker !== 1'b1) begin miscompares++; $display("FAIL glitch_speaker cycle %0d got %b exp 1", i, speaker); end
            vectors++; if (digits !== EXP_AUTO2) begin miscompares++; $display("FAIL glitch_digits cycle %0d got %h exp %h", i, digits, EXP_AUTO2); end
        end
    endtask

    task automatic test_learn;
        user = 2'd1; song_num = 2'd3;
        go_mode(MODE_LEARN);
        vectors++; if (digits !== EXP_LRN3) begin miscompares++; $display("FAIL learn_digits got %h exp %h", digits, EXP_LRN3); end
        vectors++; if (led !== 8'h3C) begin miscompares++; $display("FAIL learn_led got %h exp 3c", led); end
        vectors++; if (speaker !== 1'b1) begin miscompares++; $display("FAIL learn_speaker got %b exp 1", speaker); end
        vectors++; if (rec_score !== 33'd0) begin miscompares++; $display("FAIL learn_rec_empty got %0d exp 0", rec_score); end
        finished = 1'b1; score = 33'd50;
        step(1);
        finished = 1'b0;
        vectors++; if (digits !== EXP_RES13) begin miscompares++; $display("FAIL result_digits got %h exp %h", digits, EXP_RES13); end
        vectors++; if (new_best !== 1'b1) begin miscompares++; $display("FAIL result_new_best got %b exp 1", new_best); end
        vectors++; if (rec_score !== 33'd50) begin miscompares++; $display("FAIL result_rec got %0d exp 50", rec_score); end
        step(7);
        vectors++; if (digits !== EXP_RES13) begin miscompares++; $display("FAIL result_hold got %h exp %h", digits, EXP_RES13); end
        step(1);
        vectors++; if (digits !== EXP_LRN3) begin miscompares++; $display("FAIL result_exit got %h exp %h", digits, EXP_LRN3); end
        vectors++; if (new_best !== 1'b0) begin miscompares++; $display("FAIL result_exit_nb got %b exp 0", new_best); end
    endtask

    task automatic test_lower_then_higher;
        finished = 1'b1; score = 33'd40;
        step(1);
        finished = 1'b0;
        vectors++; if (new_best !== 1'b0) begin miscompares++; $display("FAIL low_new_best got %b exp 0", new_best); end
        vectors++; if (rec_score !== 33'd50) begin miscompares++; $display("FAIL low_rec got %0d exp 50", rec_score); end
        user = 2'd2;
        step(1);
        vectors++; if (rec_score !== 33'd0) begin miscompares++; $display("FAIL other_user_rec got %0d exp 0", rec_score); end
        vectors++; if (digits !== EXP_RES13) begin miscompares++; $display("FAIL latched_us got %h exp %h", digits, EXP_RES13); end
        user = 2'd1;
        step(1);
        vectors++; if (rec_score !== 33'd50) begin miscompares++; $display("FAIL back_user_rec got %0d exp 50", rec_score); end
        step(6);
        vectors++; if (digits !== EXP_LRN3) begin miscompares++; $display("FAIL low_exit got %h exp %h", digits, EXP_LRN3); end
        finished = 1'b1; score = 33'd60;
        step(1);
        finished = 1'b0;
        vectors++; if (new_best !== 1'b1) begin miscompares++; $display("FAIL high_new_best got %b exp 1", new_best); end
        vectors++; if (rec_score !== 33'd60) begin miscompares++; $display("FAIL high_rec got %0d exp 60", rec_score); end
        step(8);
        vectors++; if (digits !== EXP_LRN3) begin miscompares++; $display("FAIL high_exit got %h exp %h", digits, EXP_LRN3); end
    endtask

    task automatic test_back_to_back;
        mode = MODE_FREE;
        step(4);
        finished = 1'b1; score = 33'd70;
        step(1);
        finished = 1'b0;
        vectors++; if (digits !== EXP_FREE) begin miscompares++; $display("FAIL simul_digits got %h exp %h", digits, EXP_FREE); end
        vectors++; if (rec_score !== 33'd70) begin miscompares++; $display("FAIL simul_rec got %0d exp 70", rec_score); end
        vectors++; if (speaker !== 1'b0) begin miscompares++; $display("FAIL simul_mute got %b exp 0", speaker); end
        vectors++; if (led !== 8'h00) begin miscompares++; $display("FAIL free_led got %h exp 00", led); end
        step(3);
        finished = 1'b1; score = 33'd90;
        step(1);
        finished = 1'b0;
        vectors++; if (digits !== EXP_FREE) begin miscompares++; $display("FAIL free_fin_digits got %h exp %h", digits, EXP_FREE); end
        vectors++; if (rec_score !== 33'd70) begin miscompares++; $display("FAIL free_fin_rec got %0d exp 70", rec_score); end
    endtask

    task automatic test_reset_mid;
        go_mode(MODE_LEARN);
        finished = 1'b1; score = 33'd80;
        step(1);
        finished = 1'b0;
        vectors++; if (rec_score !== 33'd80) begin miscompares++; $display("FAIL pre_reset_rec got %0d exp 80", rec_score); end
        rst = 1'b1; mode = 3'b000;
        #1;
        vectors++; if (digits !== EXP_IDLE) begin miscompares++; $display("FAIL mid_reset_digits got %h exp %h", digits, EXP_IDLE); end
        vectors++; if (rec_score !== 33'd0) begin miscompares++; $display("FAIL mid_reset_rec got %0d exp 0", rec_score); end
        vectors++; if (new_best !== 1'b0) begin miscompares++; $display("FAIL mid_reset_nb got %b exp 0", new_best); end
        vectors++; if (led !== 8'h00) begin miscompares++; $display("FAIL mid_reset_led got %h exp 00", led); end
        step(1);
        rst = 1'b0;
        for (int u = 0; u < 4; u++)
            for (int s = 0; s < 4; s++) begin
                user = 2'(u); song_num = 2'(s);
                step(1);
                vectors++; if (rec_score !== 33'd0) begin miscompares++; $display("FAIL cleared_rec u%0d s%0d got %0d exp 0", u, s, rec_score); end
            end
    endtask

    initial begin
        test_reset();
        test_auto();
        test_glitch();
        test_learn();
        test_lower_then_higher();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mode_sequencer.md
# mode_sequencer

Parametrised, fully registered top-level mode controller for the piano. It selects speaker, LED and 7-segment digit sources among the auto-player, free-play keyboard and learning engine. Mode-switch debounce, switch-click muting and a result screen with timed exit are built in. A per-user, per-song best-score table replaces the old latch-inferred record array. The block sits between the player engines and `seg_display`/`score2level` in the top level.

## Interface
- NUM_USERS, 4, number of user slots (power of 2, ≥2)
- NUM_SONGS, 4, number of songs (power of 2, ≥2)
- SCORE_W, 33, score width
- SETTLE_CYCLES, 1_000_000, cycles `mode` must stay stable before commit
- MUTE_CYCLES, 500_000, speaker forced low after each committed state change
- RESULT_HOLD, 500_000_000, cycles the result screen is shown before returning to LEARN
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mode  in  3  011 auto, 001 free, 111 learning, other idle
- song_num  in  log2(NUM_SONGS)  selected song
- user  in  log2(NUM_USERS)  selected user
- spk_src  in  3  [0] auto, [1] free, [2] learning speaker
- led_auto, led_learn  in  8  engine LED patterns
- finished  in  1  learning engine done (level)
- score  in  SCORE_W  learning score, valid while finished=1
- level_digits  in  20  four 5-bit codes from score2level, p3..p0
- speaker  out  1  registered speaker
- led  out  8  registered LEDs
- digits  out  40  p7..p0 as 5-bit codes to seg_display
- rec_score  out  SCORE_W  stored best for {user, song_num}, feeds score2level
- new_best  out  1  last result set a new best

## Operation
- States: IDLE, AUTO, FREE, LEARN, RESULT. Reset → IDLE.
- Debounce: `cand` register tracks `mode`. A counter clears whenever `mode != cand` and counts otherwise. When the count reaches SETTLE_CYCLES-1, the decoded target commits. Commit is ignored if the target equals the current base state (RESULT counts as LEARN).
- Each commit that changes state loads the mute counter to MUTE_CYCLES. speaker=0 while the counter is nonzero.
- IDLE: digits = HELLO, EMPTY3; led=0; speaker=0.
- AUTO: digits = AUTO, EMPTY3, song digit; led=led_auto; speaker=spk_src[0].
- FREE: digits = FREE, EMPTY4; led=0; speaker=spk_src[1].
- LEARN: digits = LRN, EMPTY4, song digit; led=led_learn; speaker=spk_src[2].
- LEARN→RESULT on a finished rising edge (finished & ~finished_q).
- On that same edge, record idx={user,song_num} is written when its valid bit is clear or score > stored value. new_best is set to 1 if the record was written, else 0.
- RESULT: digits = 'U', user, 'S', song, level_digits; led=led_learn; speaker=spk_src[2].
- RESULT→LEARN after RESULT_HOLD cycles, or immediately on any committed mode change (to that mode).
- new_best clears on leaving RESULT.
- Record table: NUM_USERS·NUM_SONGS entries plus valid bits, synchronous read. An invalid entry reads as 0.
- Simultaneous commit and finished edge: the score is still recorded, and the state goes to the committed mode, not RESULT.
- A finished edge outside LEARN is ignored.
- A user/song change in RESULT updates rec_score but the displayed U/S digits stay latched from entry.

## Timing
- All outputs are registered: 1-cycle latency from spk_src, led_*, level_digits and state to the outputs.
- rec_score is valid 1 cycle after an idx change or a table write (write-first on the same idx).
- Mode change to output takes SETTLE_CYCLES + 1 cycles. Mute starts on the commit cycle +1.
- Reset values: speaker=0, led=0, digits=HELLO/EMPTY3, rec_score=0, new_best=0, all valid bits=0, counters=0, state=IDLE.
- Reset mid-operation clears the table and aborts RESULT with no write.

## Structure
- The shared const package holds the AUTO, FREE, LRN, HELLO, EMPTY3, EMPTY4, 'U' and 'S' digit codes, the mode encodings and the state enum.
- One sub-module, `score_record_table` (parametrised RAM with valid bits, compare-and-write, sync read). Debounce, mute and the FSM stay in `mode_sequencer`.

## Test plan
Bench parameters: SETTLE_CYCLES=4, MUTE_CYCLES=3, RESULT_HOLD=8.
- Reset, then mode=011, song=2 → digits show AUTO plus song digit 2 on cycle 5. speaker=0 for cycles 5–7, then follows spk_src[0].
- mode glitches 001 for 2 cycles, back to 011 → no state change and no mute.
- LEARN, user=1, song=3, finished edge with score=50 → RESULT, new_best=1, rec_score=50 next cycle. After 8 cycles, state returns to LEARN and new_best=0.
- Same idx, score=40 → RESULT, new_best=0, rec_score stays 50. A later score=60 → new_best=1, rec_score=60.
- Commit to FREE on the same cycle as a finished edge with score=70 → state FREE (not RESULT); record becomes 70.
- Assert rst during RESULT → outputs at reset values; rec_score=0 for every idx afterwards.
